// File: rtl/gray_arb_pkg.sv
// Shared helpers for the gray-decode arbiter: channel-index width,
// gray-to-binary prefix XOR, and a "more than one bit set" test.
// Functions work on a fixed maximum width. Callers zero-extend narrower
// words into that width, which leaves the low bits of each result unchanged.
package gray_arb_pkg;

    localparam int GRAY_MAX_W = 64;

    // Width of a channel index, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Each binary bit is the XOR of its gray bit and every gray bit above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [GRAY_MAX_W-1:0] x);
        return (x & (x - GRAY_MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_rr_arbiter.sv
// Round-robin grant: searches req starting one past last_grant, wrapping,
// and raises the one-hot grant bit of the first requester found.
// The grant is forced to zero when enable is low.
module gray_rr_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant
);

    logic found;
    int   idx;

    // Walk the channels in priority order. The first valid request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!found && req[idx]) begin
                grant[idx] = enable;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Shares one gray-to-binary decoder among NUM_CH requesters. A round-robin
// grant picks one requester per cycle. The decoded word is registered onto a
// single valid/ready output, tagged with its channel.
// Optional macro GRAY_ARB_STEP_CHECK_EN enables a per-channel check. It
// flags any gray sample that differs from that channel's previous sample in
// more than one bit.
module gray_decode_arbiter
    import gray_arb_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter int   NUM_CH     = 4,
    localparam int  CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_gray,
    output logic [NUM_CH-1:0]            req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_bin,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_step_err
);

    logic [DATA_WIDTH-1:0] gray_ch [NUM_CH];
    logic [NUM_CH-1:0]     grant;
    logic                  load;
    logic                  xfer;
    logic [CH_W-1:0]       win_idx;
    logic [DATA_WIDTH-1:0] win_gray;
    logic [DATA_WIDTH-1:0] bin_next;

    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_bin_reg;
    logic [CH_W-1:0]       out_ch_reg;
    logic [CH_W-1:0]       last_grant_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign gray_ch[gi] = req_gray[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The output register can take a new word when empty or being drained.
    assign load = !out_valid_reg || out_ready;

    gray_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .enable     (load),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // Encode the one-hot grant and select the winning channel's gray word.
    always_comb begin
        win_idx  = '0;
        win_gray = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                win_idx  = CH_W'(c);
                win_gray = gray_ch[c];
            end
        end
    end

    assign bin_next = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(win_gray)));

    // Output register and pointer. Data holds across drain and backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_reg  <= 1'b0;
            out_bin_reg    <= '0;
            out_ch_reg     <= '0;
            last_grant_reg <= CH_W'(NUM_CH - 1);
        end else begin
            if (load) begin
                out_valid_reg <= xfer;
            end
            if (xfer) begin
                out_bin_reg    <= bin_next;
                out_ch_reg     <= win_idx;
                last_grant_reg <= win_idx;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bin   = out_bin_reg;
    assign out_ch    = out_ch_reg;

`ifdef GRAY_ARB_STEP_CHECK_EN
    logic [DATA_WIDTH-1:0] prev_gray_reg [NUM_CH];
    logic [NUM_CH-1:0]     seen_reg;
    logic                  step_err_reg;
    logic                  step_err_next;

    // A multi-bit jump is an error only once the channel has a history.
    always_comb begin
        step_err_next = seen_reg[win_idx] &&
                        popcount_gt1(GRAY_MAX_W'(win_gray ^ prev_gray_reg[win_idx]));
    end

    // Remember each channel's last transferred sample and flag the new one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seen_reg     <= '0;
            step_err_reg <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                prev_gray_reg[c] <= '0;
            end
        end else if (xfer) begin
            step_err_reg           <= step_err_next;
            prev_gray_reg[win_idx] <= win_gray;
            seen_reg[win_idx]      <= 1'b1;
        end
    end

    assign out_step_err = step_err_reg;
`else
    assign out_step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed bench for gray_decode_arbiter (DATA_WIDTH=16, NUM_CH=4).
// Expected values below are hand-computed gray decodes and round-robin orders.
module tb_gray_decode_arbiter;

    localparam int DW = 16;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [NC-1:0] req_valid;
    logic [NC*DW-1:0] req_gray;
    logic [NC-1:0] req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_bin;
    logic [1:0]    out_ch;
    logic          out_step_err;

    int checks   = 0;
    int failures = 0;

    gray_decode_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_gray     (req_gray),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bin      (out_bin),
        .out_ch       (out_ch),
        .out_step_err (out_step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_gray(input int ch, input logic [DW-1:0] g);
        req_gray[ch*DW +: DW] = g;
    endtask

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    // One line per observed output transaction.
    task automatic show_out(input string what);
        $display("%s: out_valid=%0d out_ch=%0d out_bin=%h step_err=%0d",
                 what, out_valid, out_ch, out_bin, out_step_err);
    endtask

    logic [DW-1:0] exp_bin [NC];

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_gray  = '0;
        out_ready = 1'b1;
        #12;
        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin",   out_bin, 0);
        check("rst_out_ch",    out_ch, 0);
        check("rst_step_err",  out_step_err, 0);
        check("rst_req_ready", req_ready, 0);
        do_reset();

        // Single request on ch2, gray 000B decodes to 000D
        set_gray(2, 16'h000B);
        req_valid = 4'b0100;
        #1 check("t1_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_bin",   out_bin, 16'h000D);
        check("t1_out_ch",    out_ch, 2);
        show_out("t1 xfer");
        tick();
        check("t1_drain_valid", out_valid, 0);
        check("t1_drain_bin",   out_bin, 16'h000D);
        check("t1_drain_ch",    out_ch, 2);

        // All channels valid after reset: grants 0,1,2,3,0,... with no bubbles.
        // Channel words double as decode boundary cases.
        do_reset();
        set_gray(0, 16'h0000); exp_bin[0] = 16'h0000;
        set_gray(1, 16'h8000); exp_bin[1] = 16'hFFFF;
        set_gray(2, 16'hFFFF); exp_bin[2] = 16'hAAAA;
        set_gray(3, 16'h0001); exp_bin[3] = 16'h0001;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check("t2_req_ready", req_ready, 32'(1 << (i % NC)));
            tick();
            check("t2_out_valid", out_valid, 1);
            check("t2_out_ch",    out_ch, i % NC);
            check("t2_out_bin",   out_bin, exp_bin[i % NC]);
            check("t2_step_err",  out_step_err, 0);
            show_out("t2 xfer");
        end

        // Load ch1, then hold it under backpressure while ch0/ch3 request
        req_valid = 4'b0010;
        #1 check("t3_req_ready_ch1", req_ready, 4'b0010);
        tick();
        check("t3_out_ch1", out_ch, 1);
        out_ready = 1'b0;
        req_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            #1 check("t3_bp_req_ready", req_ready, 0);
            tick();
            check("t3_bp_valid", out_valid, 1);
            check("t3_bp_ch",    out_ch, 1);
            check("t3_bp_bin",   out_bin, 16'hFFFF);
        end
        out_ready = 1'b1;
        #1 check("t3_release_req_ready", req_ready, 4'b1000);
        tick();
        check("t3_release_ch",  out_ch, 3);
        check("t3_release_bin", out_bin, 16'h0001);
        show_out("t3 xfer");

        // Move pointer to ch2, then reset asynchronously with a word in flight
        req_valid = 4'b0100;
        tick();
        check("t4_pre_ch", out_ch, 2);
        check("t4_pre_valid", out_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("t4_async_valid", out_valid, 0);
        check("t4_async_bin",   out_bin, 0);
        check("t4_async_ch",    out_ch, 0);
        @(negedge clk);
        resetn    = 1'b1;
        req_valid = 4'b1111;
        #1 check("t4_prio_req_ready", req_ready, 4'b0001);
        tick();
        check("t4_prio_ch", out_ch, 0);
        req_valid = '0;
        tick();

`ifdef GRAY_ARB_STEP_CHECK_EN
        // ch1 gray sequence 0000, 0001, 0003, 0000; the last step is a two-bit jump
        do_reset();
        begin
            logic [DW-1:0] seq [4];
            logic          err [4];
            seq[0] = 16'h0000; err[0] = 1'b0;
            seq[1] = 16'h0001; err[1] = 1'b0;
            seq[2] = 16'h0003; err[2] = 1'b0;
            seq[3] = 16'h0000; err[3] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                set_gray(1, seq[i]);
                req_valid = 4'b0010;
                tick();
                check("t5_ch",       out_ch, 1);
                check("t5_step_err", out_step_err, err[i]);
                show_out("t5 xfer");
            end
        end
        // First ch0 sample after reset is never flagged
        set_gray(0, 16'hFFFF);
        req_valid = 4'b0001;
        tick();
        check("t5_first_ch0_ch",  out_ch, 0);
        check("t5_first_ch0_err", out_step_err, 0);
        req_valid = '0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_decode_arbiter.md
Name: gray_decode_arbiter

Overview:
- Shares one gray-to-binary decoder among NUM_CH requesters.
- Each requester presents a gray-coded word under a valid/ready handshake. The block grants one requester per cycle in round-robin order.
- The granted word is decoded and registered on a single valid/ready output stream tagged with the channel ID.
- Sits between gray-coded sources (pointer/position counters) and a common binary consumer.

Parameters:
- DATA_WIDTH, 16, width of each gray word and of the binary result.
- NUM_CH, 4, number of requesters; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_gray  in  NUM_CH*DATA_WIDTH  per-channel gray word; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accept.
- out_bin  out  DATA_WIDTH  decoded binary word.
- out_ch  out  CH_W  index of the channel that produced out_bin; CH_W = max(1, clog2(NUM_CH)).
- out_step_err  out  1  step-check flag, qualified by out_valid (see Optional Feature).

Behaviour:
- Reset (asynchronous, resetn=0):
  - out_valid=0, out_bin=0, out_ch=0, out_step_err=0.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 has highest priority first.
- Output register load enable: load = !out_valid || out_ready (one-entry pipeline, full throughput).
- Arbitration (combinational):
  - Search req_valid starting at last_grant+1 mod NUM_CH, wrapping.
  - The first set bit is the winner.
  - req_ready[winner] = load. All other req_ready bits are 0. req_ready is 0 for every channel when load=0 or no req_valid is set.
- Transfer: on a clock edge with req_valid[c] && req_ready[c]:
  - out_bin <= decode(gray_c), out_ch <= c, out_valid <= 1, last_grant <= c.
- Decode rule:
  - bin[DATA_WIDTH-1] = gray[DATA_WIDTH-1].
  - bin[i] = bin[i+1] ^ gray[i] for i descending to 0.
  - Purely combinational ahead of the output register.
- Latency: 1 cycle from accepted request to out_valid.
- Drain: if load=1 and no request, out_valid <= 0 after out_ready; out_bin and out_ch hold their last value.
- Backpressure: while out_valid && !out_ready, out_bin, out_ch and out_step_err stay stable. No request is accepted.
- Simultaneous out_ready and new request: the consumer takes the old word and the new word loads in the same edge; no bubble.
- last_grant updates only on an actual transfer; idle cycles keep the priority order.
- Requesters may drop req_valid without a transfer; no state is kept for them.
- Reset asserted mid-transfer: all outputs and the pointer return to reset values immediately. Any in-flight word is lost.

Optional Feature:
- Macro: GRAY_ARB_STEP_CHECK_EN.
- Defined:
  - Per-channel registers keep prev_gray[c] and seen[c]; both reset to 0.
  - On each transfer from c: out_step_err <= seen[c] && (popcount(gray_c ^ prev_gray[c]) > 1). Then prev_gray[c] <= gray_c and seen[c] <= 1.
  - Zero change and single-bit change are legal.
  - The first sample per channel after reset is never flagged.
- Undefined: no per-channel storage; out_step_err is tied to 0. Ports are identical in both builds.

Decomposition:
- Package gray_arb_pkg holds:
  - the CH_W computation as a function clog2_min1(n);
  - function gray2bin(gray) returning the prefix-XOR result;
  - function popcount_gt1(x).
- Sub-module gray_rr_arbiter: NUM_CH-wide round-robin grant logic with inputs req, last_grant and enable, and output one-hot grant.
- Decoder, output register and step check live in the top.

Test Plan:
- Reset then a single request: ch2 valid, gray=16'h000B, out_ready=1 -> req_ready=4'b0100 in cycle 0. Cycle 1: out_valid=1, out_bin=16'h000D, out_ch=2.
- All four valid every cycle, out_ready=1 -> grants in order 0,1,2,3,0,... with one transfer per cycle and no bubbles. Check out_ch sequence over 8 cycles.
- Backpressure: out_valid=1 holding ch1, out_ready=0 for 3 cycles while ch0/ch3 are valid -> req_ready=0, out_bin stable. Release -> ch3 is next (last_grant=1 search order 2,3,0 gives 3).
- Decode boundaries: gray 16'h0000 -> 0; 16'h8000 -> 16'hFFFF; 16'hFFFF -> 16'hAAAA; 16'h0001 -> 16'h0001.
- Reset mid-stream with out_valid=1 -> out_valid=0 asynchronously. After release, ch0 has top priority.
- With GRAY_ARB_STEP_CHECK_EN, ch1 sequence 0x0000, 0x0001, 0x0003, 0x0000:
  - out_step_err = 0, 0, 0, 1 respectively.
  - First sample of ch0 = 0xFFFF -> out_step_err=0.
